// File: rtl/gpio_seg_display.sv
// gpio_seg_display: renders the CPU gpio_out word on eight seven-segment digits.
// Hex mode shows the raw nibbles. Decimal mode converts the word with a serial
// double-dabble, one bit per clock, and shows the low eight decimal digits.
// The display is only re-rendered when value, mode or blank_lz change, and
// outputs keep their previous pattern until the new one is ready.
module gpio_seg_display #(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value,
    input  logic        mode,
    input  logic        blank_lz,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [6:0]  hex6,
    output logic [6:0]  hex7,
    output logic        ovf,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam logic [6:0] BLANK_PAT = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    // Digit to segment pattern; the table is written active-low (g..a).
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'h0: p = 7'h40;
            4'h1: p = 7'h79;
            4'h2: p = 7'h24;
            4'h3: p = 7'h30;
            4'h4: p = 7'h19;
            4'h5: p = 7'h12;
            4'h6: p = 7'h02;
            4'h7: p = 7'h78;
            4'h8: p = 7'h00;
            4'h9: p = 7'h10;
            4'hA: p = 7'h08;
            4'hB: p = 7'h03;
            4'hC: p = 7'h46;
            4'hD: p = 7'h21;
            4'hE: p = 7'h06;
            default: p = 7'h0E;
        endcase
        return SEG_ACTIVE_LOW ? p : ~p;
    endfunction

    state_t      state_q;
    logic [31:0] sh_value_q;
    logic        sh_mode_q;
    logic        sh_blank_q;
    logic        refresh_pending_q;
    logic [39:0] bcd_q;
    logic [31:0] sreg_q;
    logic [4:0]  cnt_q;
    logic [6:0]  hex_q [8];
    logic        ovf_q;
    logic        busy_q;

    logic [39:0] bcd_adj;
    logic [3:0]  digit [8];
    logic [7:0]  blank_mask;
    logic [6:0]  hex_d [8];
    logic        ovf_d;
    logic        trigger;

    genvar gi;

    // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift.
    generate
        for (gi = 0; gi < 10; gi++) begin : g_dabble
            assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                        bcd_q[4*gi +: 4] + 4'd3 : bcd_q[4*gi +: 4];
        end
    endgenerate

    // Select the digit source for the rendered mode.
    generate
        for (gi = 0; gi < 8; gi++) begin : g_digit
            assign digit[gi] = sh_mode_q ? bcd_q[4*gi +: 4] : sh_value_q[4*gi +: 4];
        end
    endgenerate

    assign ovf_d   = sh_mode_q && (bcd_q[39:32] != 8'd0);
    assign trigger = refresh_pending_q || (value != sh_value_q) ||
                     (mode != sh_mode_q) || (blank_lz != sh_blank_q);

    // Leading-zero mask: a digit blanks when it and every higher digit are zero;
    // digit 0 always stays visible, and overflow disables blanking entirely.
    always_comb begin
        logic run;
        run        = 1'b1;
        blank_mask = '0;
        for (int i = 7; i >= 0; i--) begin
            run           = run && (digit[i] == 4'd0);
            blank_mask[i] = (i != 0) && sh_blank_q && !ovf_d && run;
        end
    end

    // Final per-digit pattern, captured into the output registers in UPDATE.
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pattern
            assign hex_d[gi] = blank_mask[gi] ? BLANK_PAT : seg_encode(digit[gi]);
        end
    endgenerate

    // Control FSM: accept changes in IDLE, convert in SHIFT, publish in UPDATE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= IDLE;
            sh_value_q        <= '0;
            sh_mode_q         <= 1'b0;
            sh_blank_q        <= 1'b0;
            refresh_pending_q <= 1'b1;
            bcd_q             <= '0;
            sreg_q            <= '0;
            cnt_q             <= '0;
            ovf_q             <= 1'b0;
            busy_q            <= 1'b0;
            for (int i = 0; i < 8; i++) hex_q[i] <= BLANK_PAT;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        sh_value_q        <= value;
                        sh_mode_q         <= mode;
                        sh_blank_q        <= blank_lz;
                        refresh_pending_q <= 1'b0;
                        bcd_q             <= '0;
                        cnt_q             <= '0;
                        sreg_q            <= value;
                        busy_q            <= 1'b1;
                        state_q           <= mode ? SHIFT : UPDATE;
                    end
                end
                SHIFT: begin
                    bcd_q  <= {bcd_adj[38:0], sreg_q[31]};
                    sreg_q <= {sreg_q[30:0], 1'b0};
                    cnt_q  <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= UPDATE;
                end
                UPDATE: begin
                    for (int i = 0; i < 8; i++) hex_q[i] <= hex_d[i];
                    ovf_q   <= ovf_d;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];
    assign hex6 = hex_q[6];
    assign hex7 = hex_q[7];
    assign ovf  = ovf_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_gpio_seg_display.sv
// Testbench for gpio_seg_display: directed vectors with literal expectations,
// plus a latency-level reference model checked every cycle.
module tb_gpio_seg_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] value = '0;
    logic        mode = 1'b0;
    logic        blank_lz = 1'b0;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic        ovf, busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gpio_seg_display #(.SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .value(value), .mode(mode), .blank_lz(blank_lz),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7),
        .ovf(ovf), .busy(busy)
    );

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected display for a word: plain arithmetic digit extraction.
    function automatic logic [55:0] render(input logic [31:0] v, input logic m,
                                           input logic b, output logic o);
        int d [8];
        longint unsigned x;
        int h;
        x = 64'(v);
        for (int i = 0; i < 8; i++) begin
            if (m) begin
                d[i] = int'(x % 10);
                x = x / 10;
            end else begin
                d[i] = int'((v >> (4 * i)) & 32'hF);
            end
        end
        o = m && (x != 0);
        h = 0;
        for (int i = 0; i < 8; i++) if (d[i] != 0) h = i;
        render = '0;
        for (int i = 0; i < 8; i++)
            render[7*i +: 7] = (b && !o && i > h) ? 7'h7F : seg_tab[d[i]];
    endfunction

    // Reference model: accept when idle and something changed, publish after the latency.
    logic [31:0] m_value = '0;
    logic        m_mode = 1'b0, m_blank = 1'b0, m_pending = 1'b1;
    int          m_remaining = 0;
    logic [55:0] m_hex = {8{7'h7F}};
    logic        m_ovf = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_value = '0; m_mode = 1'b0; m_blank = 1'b0; m_pending = 1'b1;
            m_remaining = 0; m_hex = {8{7'h7F}}; m_ovf = 1'b0;
        end else if (m_remaining == 0) begin
            if (m_pending || value != m_value || mode != m_mode || blank_lz != m_blank) begin
                m_value = value; m_mode = mode; m_blank = blank_lz; m_pending = 1'b0;
                m_remaining = mode ? 33 : 1;
            end
        end else begin
            m_remaining--;
            if (m_remaining == 0) m_hex = render(m_value, m_mode, m_blank, m_ovf);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("cyc_hex", 64'({hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0}), 64'(m_hex));
        chk("cyc_ovf", 64'(ovf), 64'(m_ovf));
        chk("cyc_busy", 64'(busy), 64'(m_remaining != 0));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply(input logic [31:0] v, input logic m, input logic b);
        value = v; mode = m; blank_lz = b;
    endtask

    function automatic logic [63:0] disp();
        return 64'({hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0});
    endfunction

    initial begin
        int bcnt;
        // Reset state
        tick(2);
        chk("rst_hex", disp(), 64'({8{7'h7F}}));
        chk("rst_busy", 64'(busy), 64'(0));
        $display("txn reset: hex=%h", disp());
        rst = 1'b0;
        tick(2);
        chk("zero_hex", disp(), 64'({8{7'h40}}));
        chk("zero_ovf", 64'(ovf), 64'(0));
        chk("zero_busy", 64'(busy), 64'(0));
        $display("txn value=0 hex: hex=%h", disp());

        // Hex with leading-zero blanking
        apply(32'h00BC614E, 1'b0, 1'b1);
        tick(2);
        chk("hex_bc614e", disp(), 64'({7'h7F, 7'h7F, 7'h03, 7'h46, 7'h02, 7'h79, 7'h19, 7'h06}));
        $display("txn 00BC614E hex: hex=%h", disp());

        // Decimal 12345678, busy window and hold
        apply(32'h00BC614E, 1'b1, 1'b0);
        bcnt = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (busy) bcnt++;
            if (i == 33)
                chk("dec_hold", disp(), 64'({7'h7F, 7'h7F, 7'h03, 7'h46, 7'h02, 7'h79, 7'h19, 7'h06}));
            if (i == 34) begin
                chk("dec_12345678", disp(), 64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}));
                chk("dec_ovf0", 64'(ovf), 64'(0));
            end
        end
        chk("busy_cycles", 64'(bcnt), 64'(33));
        $display("txn 12345678 dec: hex=%h busy_cycles=%0d", disp(), bcnt);

        // Overflow suppresses blanking
        apply(32'hFFFFFFFF, 1'b1, 1'b1);
        tick(34);
        chk("ovf_digits", disp(), 64'({7'h10, 7'h19, 7'h10, 7'h02, 7'h78, 7'h24, 7'h10, 7'h12}));
        chk("ovf_flag", 64'(ovf), 64'(1));
        $display("txn FFFFFFFF dec: hex=%h ovf=%0d", disp(), ovf);

        // Change during conversion: 5 shows first, then 7
        apply(32'd5, 1'b1, 1'b1);
        tick(10);
        value = 32'd7;
        tick(24);
        chk("mid_five", disp(), 64'({{7{7'h7F}}, 7'h12}));
        $display("txn 5 dec: hex=%h", disp());
        tick(34);
        chk("mid_seven", disp(), 64'({{7{7'h7F}}, 7'h78}));
        $display("txn 7 dec: hex=%h", disp());

        // Reset during SHIFT, then re-render
        apply(32'd1234, 1'b1, 1'b1);
        tick(10);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_hex", disp(), 64'({8{7'h7F}}));
        chk("async_rst_busy", 64'(busy), 64'(0));
        chk("async_rst_ovf", 64'(ovf), 64'(0));
        tick(1);
        #2 rst = 1'b0;
        tick(34);
        chk("rerender_1234", disp(), 64'({{4{7'h7F}}, 7'h79, 7'h24, 7'h30, 7'h19}));
        $display("txn 1234 after reset: hex=%h", disp());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
